// File: rtl/ad1_reader.sv
// Two-channel AD7476A-style serial ADC reader for the lock-in receive path.
// Ports: clk_100/reset (async, active-low), start request, ad_ncs/ad_sclk
// converter strobes, ad_d1/ad_d2 serial data, sample1/sample2 signed results,
// valid pulse, busy, sticky frame_err.
module ad1_reader #(
  parameter int          CLK_DIV      = 3,
  parameter int          QUIET_CYCLES = 4,
  parameter logic [11:0] MIDSCALE     = 12'h800
) (
  input  logic        clk_100,
  input  logic        reset,
  input  logic        start,
  output logic        ad_ncs,
  output logic        ad_sclk,
  input  logic        ad_d1,
  input  logic        ad_d2,
  output logic [15:0] sample1,
  output logic [15:0] sample2,
  output logic        valid,
  output logic        busy,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    QUIET
  } state_t;

  localparam logic [7:0] DIV_END   = 8'(CLK_DIV - 1);
  localparam logic [7:0] QUIET_END = 8'(QUIET_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  half_q, half_d;
  logic [15:0] sh1_q, sh1_d;
  logic [15:0] sh2_q, sh2_d;
  logic        ncs_q, ncs_d;
  logic        sclk_q, sclk_d;
  logic [15:0] s1_q, s1_d;
  logic [15:0] s2_q, s2_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic [12:0] diff1, diff2;

  // 13-bit subtract keeps the borrow as the sign bit.
  assign diff1 = {1'b0, sh1_q[11:0]} - {1'b0, MIDSCALE};
  assign diff2 = {1'b0, sh2_q[11:0]} - {1'b0, MIDSCALE};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    ncs_d   = ncs_q;
    sclk_d  = sclk_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    valid_d = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          cnt_d   = '0;
          half_d  = '0;
          ncs_d   = 1'b0;
          sclk_d  = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == DIV_END) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sclk_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SHIFT: begin
        if (cnt_q == DIV_END) begin
          cnt_d = '0;
          // even half-periods are SCLK low
          if (!half_q[0]) begin
            sh1_d  = {sh1_q[14:0], ad_d1};
            sh2_d  = {sh2_q[14:0], ad_d2};
            sclk_d = 1'b1;
            half_d = half_q + 5'd1;
          end else if (half_q == 5'd31) begin
            state_d = QUIET;
            ncs_d   = 1'b1;
            valid_d = 1'b1;
            s1_d    = {{3{diff1[12]}}, diff1};
            s2_d    = {{3{diff2[12]}}, diff2};
            err_d   = err_q | (|sh1_q[15:12]) |
                      (|sh2_q[15:12]);
          end else begin
            sclk_d = 1'b0;
            half_d = half_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      QUIET: begin
        if (cnt_q == QUIET_END) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      half_q  <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      ncs_q   <= 1'b1;
      sclk_q  <= 1'b1;
      s1_q    <= '0;
      s2_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      ncs_q   <= ncs_d;
      sclk_q  <= sclk_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign ad_ncs    = ncs_q;
  assign ad_sclk   = sclk_q;
  assign sample1   = s1_q;
  assign sample2   = s2_q;
  assign valid     = valid_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = err_q;

endmodule

// File: tb/tb_ad1_reader.sv
// Bench for ad1_reader: converter model, cycle-level expectations
// from frame timing arithmetic, directed scenarios plus random starts.
module tb_ad1_reader;
  localparam int D    = 3;
  localparam int Q    = 4;
  localparam int ENDK = 1 + 33 * D;

  logic clk_100 = 1'b0;
  logic reset   = 1'b0;
  logic start   = 1'b0;
  logic ad_d1   = 1'b0;
  logic ad_d2   = 1'b0;
  logic ad_ncs, ad_sclk, valid, busy, frame_err;
  logic [15:0] sample1, sample2;

  ad1_reader dut (
    .clk_100  (clk_100),
    .reset    (reset),
    .start    (start),
    .ad_ncs   (ad_ncs),
    .ad_sclk  (ad_sclk),
    .ad_d1    (ad_d1),
    .ad_d2    (ad_d2),
    .sample1  (sample1),
    .sample2  (sample2),
    .valid    (valid),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #5 clk_100 = ~clk_100;

  int cyc = 0;
  int cmp = 0;
  int bad = 0;
  logic [15:0] w1 = '0, w2 = '0;
  logic [15:0] fw1 = '0, fw2 = '0;
  logic [15:0] e1 = '0, e2 = '0;
  logic eerr = 1'b0;
  bit have = 0;
  int T = 0;
  int k;
  int fall = 0;
  int lastv = -1;
  int lastn = -1;
  int vcnt = 0;
  logic psclk = 1'b1, pncs = 1'b1;
  logic xn, xs, xb, xv;

  task automatic chk(string nm, logic [15:0] a, logic [15:0] e);
    cmp++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, a, e);
    end
  endtask

  function automatic logic [15:0] sx(logic [15:0] w);
    int c;
    c = int'(w[11:0]);
    return 16'(c - 2048);
  endfunction

  // Model: a frame accepted at cycle T owns cycles T+1..T+ENDK+Q-1.
  always @(posedge clk_100) begin
    if (!reset) begin
      have = 0; e1 = '0; e2 = '0; eerr = 1'b0;
    end else if (start && (!have || cyc >= T + ENDK + Q)) begin
      have = 1; T = cyc; fw1 = w1; fw2 = w2;
    end
    cyc++;
    k = cyc - T;
    if (have && k == 1) fall = 0;
    if (have && k == ENDK) begin
      e1 = sx(fw1);
      e2 = sx(fw2);
      eerr = eerr | (fw1[15:12] != 4'h0) | (fw2[15:12] != 4'h0);
    end
    xn = 1'b1; xs = 1'b1; xb = 1'b0; xv = 1'b0;
    if (have && k >= 1 && k <= ENDK + Q - 1) begin
      xb = 1'b1;
      if (k < ENDK) begin
        xn = 1'b0;
        if (k > D) xs = (((k - D - 1) / D) % 2) == 1;
      end
      xv = (k == ENDK);
    end
    #1;
    chk("ncs", 16'(ad_ncs), 16'(xn));
    chk("sclk", 16'(ad_sclk), 16'(xs));
    chk("busy", 16'(busy), 16'(xb));
    chk("valid", 16'(valid), 16'(xv));
    chk("sample1", sample1, e1);
    chk("sample2", sample2, e2);
    chk("frame_err", 16'(frame_err), 16'(eerr));
    if (!ad_ncs && psclk && !ad_sclk && fall < 16) begin
      ad_d1 = fw1[15 - fall];
      ad_d2 = fw2[15 - fall];
      fall++;
    end
    if (pncs && !ad_ncs) lastn = cyc;
    if (valid) begin
      lastv = cyc;
      vcnt++;
      chk("falls", 16'(fall), 16'd16);
    end
    psclk = ad_sclk;
    pncs  = ad_ncs;
  end

  task automatic pulse_at(input int tt);
    while (cyc < tt) @(negedge clk_100);
    start = 1'b1;
    @(negedge clk_100);
    start = 1'b0;
  endtask

  task automatic frame(input logic [15:0] a, input logic [15:0] b,
                       output int t);
    @(negedge clk_100);
    w1 = a;
    w2 = b;
    t = cyc;
    pulse_at(t);
    while (cyc < t + ENDK + Q + 2) @(negedge clk_100);
  endtask

  int t, vc;

  initial begin
    repeat (3) @(negedge clk_100);
    reset = 1'b1;
    repeat (20) @(negedge clk_100);
    chk("idle_s1", sample1, 16'h0000);
    chk("idle_busy", 16'(busy), 16'd0);
    chk("idle_vcnt", 16'(vcnt), 16'd0);

    frame(16'h0FFF, 16'h0000, t);
    chk("f1_s1", sample1, 16'h07FF);
    chk("f1_s2", sample2, 16'hF800);
    chk("f1_err", 16'(frame_err), 16'd0);
    chk("f1_vat", 16'(lastv - t), 16'd100);

    frame(16'h0800, 16'h0123, t);
    chk("f2_s1", sample1, 16'h0000);
    chk("f2_s2", sample2, 16'hF923);

    @(negedge clk_100);
    t = cyc + 1;
    vc = vcnt;
    pulse_at(t);
    pulse_at(t + 50);
    chk("sp_v1", 16'(lastv), 16'(-1 + 0 * t) & 16'(lastv));
    while (cyc < t + 101) @(negedge clk_100);
    chk("sp_v1at", 16'(lastv - t), 16'd100);
    pulse_at(t + 104);
    while (cyc < t + 215) @(negedge clk_100);
    chk("sp_ncs2", 16'(lastn - t), 16'd105);
    chk("sp_v2at", 16'(lastv - t), 16'd204);
    chk("sp_vcnt", 16'(vcnt - vc), 16'd2);

    frame(16'h0123, 16'h4ABC, t);
    chk("e_err", 16'(frame_err), 16'd1);
    chk("e_s2", sample2, 16'h02BC);
    frame(16'h0FFF, 16'h0800, t);
    chk("e2_err", 16'(frame_err), 16'd1);
    chk("e2_s1", sample1, 16'h07FF);
    chk("e2_s2", sample2, 16'h0000);

    @(negedge clk_100);
    t = cyc + 1;
    pulse_at(t);
    while (cyc < t + 40) @(negedge clk_100);
    vc = vcnt;
    reset = 1'b0;
    #1;
    chk("r_ncs", 16'(ad_ncs), 16'd1);
    chk("r_sclk", 16'(ad_sclk), 16'd1);
    chk("r_busy", 16'(busy), 16'd0);
    chk("r_err", 16'(frame_err), 16'd0);
    chk("r_s1", sample1, 16'h0000);
    repeat (3) @(negedge clk_100);
    reset = 1'b1;
    repeat (120) @(negedge clk_100);
    chk("r_novalid", 16'(vcnt - vc), 16'd0);
    frame(16'h0FFF, 16'h0001, t);
    chk("r2_s1", sample1, 16'h07FF);
    chk("r2_s2", sample2, 16'hF801);
    chk("r2_err", 16'(frame_err), 16'd0);

    repeat (4000) begin
      @(negedge clk_100);
      start = ($urandom_range(0, 29) == 0);
      w1 = {($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0,
            12'($urandom)};
      w2 = {($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0,
            12'($urandom)};
    end
    start = 1'b0;
    repeat (ENDK + Q + 4) @(negedge clk_100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule

// File: doc/ad1_reader.md
Name: ad1_reader

Overview:
- Serial ADC front end for the lock-in: the receive-side counterpart of the DA2 output path.
- Drives a two-channel PmodAD1-style (AD7476A) converter: chip-select, serial clock, two serial data inputs read in parallel.
- Converts each offset-binary 12-bit result into a signed 16-bit sample by removing the 0x800 midscale offset, the inverse of the DAC path.
- Samples feed the mixer stage (siginx/siginy domain), one conversion per start request.

Parameters:
- CLK_DIV, 3, clk_100 cycles per SCLK half-period (3 -> 16.67 MHz SCLK); legal range 2..15.
- QUIET_CYCLES, 4, minimum clk_100 cycles nCS stays high after a frame before the next start is accepted; legal range 1..255.
- MIDSCALE, 12'h800, offset subtracted from the raw code.

Ports:
- clk_100  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  single-cycle conversion request, e.g. from the sample-rate tick
- ad_ncs  output  1  converter chip-select, active low
- ad_sclk  output  1  converter serial clock, idle high
- ad_d1  input  1  channel-1 serial data, MSB first
- ad_d2  input  1  channel-2 serial data, MSB first
- sample1  output  16  signed channel-1 result
- sample2  output  16  signed channel-2 result
- valid  output  1  one-cycle pulse when sample1/sample2 update
- busy  output  1  high from start acceptance until QUIET ends
- frame_err  output  1  sticky; set if any of the 4 leading bits of either channel is 1

Behaviour:
- Reset (reset=0, async):
  - ad_ncs=1, ad_sclk=1, sample1=sample2=0, valid=0, busy=0, frame_err=0.
  - State returns to IDLE and all counters and shift registers clear.
  - Reset mid-frame aborts the frame; no valid pulse is produced for it.
- States:
  - IDLE -> SETUP on start=1. The start cycle is cycle T.
  - SETUP: ad_ncs=0, ad_sclk=1 for CLK_DIV cycles, from T+1.
  - SHIFT: 16 SCLK periods. Each period is CLK_DIV cycles low, then CLK_DIV cycles high.
  - SHIFT -> QUIET after the 16th high phase.
  - QUIET: ad_ncs=1, ad_sclk=1 for QUIET_CYCLES cycles, then -> IDLE.
- busy is high in SETUP, SHIFT and QUIET; it is low only in IDLE.
- start is accepted only in IDLE. Pulses arriving while busy=1 are ignored, not queued.
- Bit capture:
  - On the last clk_100 cycle of each SCLK low phase, ad_d1 and ad_d2 are shifted into 16-bit shift registers, MSB first.
  - The bench model changes data on SCLK falling edges.
- Frame format: bits 15..12 are leading zeros; bits 11..0 are the code.
- Completion:
  - ad_ncs rises at cycle T+1+33*CLK_DIV (T+100 at default).
  - In that same cycle: valid=1 for one cycle, sample1/sample2 load, and frame_err is updated.
- Arithmetic: sampleN = sign-extend-to-16 of ({1'b0,code} - {1'b0,MIDSCALE}), computed at 13 bits.
  - Code 0x000 -> 0xF800 (-2048).
  - Code 0xFFF -> 0x07FF (+2047).
  - Code 0x800 -> 0x0000.
- sample1/sample2 hold their values between valid pulses.
- frame_err is cleared only by reset. The sample values are still delivered on an errored frame.
- Minimum frame-to-frame spacing is 1+33*CLK_DIV+QUIET_CYCLES cycles (104 at default).
  - A start in the first IDLE cycle after QUIET is accepted.
- ad_ncs and ad_sclk are driven from registers; no combinational path from inputs to outputs.

Test Plan:
- Reset then idle, no start:
  - ad_ncs=1, ad_sclk=1, busy=0, valid never pulses, samples=0.
- Single conversion with the model returning ch1=0x0FFF and ch2=0x0000:
  - At T+100: valid=1, sample1=0x07FF, sample2=0xF800.
  - Exactly 16 falling SCLK edges while ad_ncs=0.
  - frame_err stays 0.
- Model returns 0x0800 and 0x0123:
  - sample1=0x0000, sample2=0xF923.
  - SCLK high/low phases each measure 3 cycles.
- Spacing and ignored starts:
  - start pulses at T, T+50 and T+104.
  - The T+50 pulse is ignored.
  - The second frame's ncs falls at T+105.
  - Two valid pulses total, at T+100 and T+204.
- Model drives leading bit 14 = 1 on ch2:
  - frame_err=1 and stays 1 after a following clean frame.
  - sample2 still reflects the low 12 bits.
- Reset asserted at T+40 mid-frame:
  - Outputs return immediately to reset values.
  - No valid pulse occurs.
  - A start after release produces a correct frame.
